// File: rtl/alu_exec_seq.sv
// Registered ALU execute stage with valid/ready handshake and zero/overflow flags.
// Optional iterative shift-add multiplier is compiled in when ALU_EXEC_MULT_EN is defined.
module alu_exec_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             invalid,
  input  logic [3:0]       inalucontrol,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             outready,
  output logic             outvalid,
  output logic [WIDTH-1:0] outresult,
  output logic             outzero,
  output logic             outoverflow
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;
  logic             w_lessThan;

  // Single-cycle datapath; anything not decoded falls through to ADD like the decoder.
  always_comb begin
    w_sum      = ina + inb;
    w_diff     = ina - inb;
    w_lessThan = ($signed(ina) < $signed(inb));
    w_result   = w_sum;
    w_overflow = (ina[WIDTH-1] == inb[WIDTH-1]) && (w_sum[WIDTH-1] != ina[WIDTH-1]);
    case (inalucontrol)
      OP_AND: begin
        w_result   = ina & inb;
        w_overflow = 1'b0;
      end
      OP_OR: begin
        w_result   = ina | inb;
        w_overflow = 1'b0;
      end
      OP_NOR: begin
        w_result   = ~(ina | inb);
        w_overflow = 1'b0;
      end
      OP_SUB: begin
        w_result   = w_diff;
        w_overflow = (ina[WIDTH-1] != inb[WIDTH-1]) && (w_diff[WIDTH-1] != ina[WIDTH-1]);
      end
      OP_SLT: begin
        w_result   = {{(WIDTH-1){1'b0}}, w_lessThan};
        w_overflow = 1'b0;
      end
      default: begin
        w_result   = w_sum;
        w_overflow = (ina[WIDTH-1] == inb[WIDTH-1]) && (w_sum[WIDTH-1] != ina[WIDTH-1]);
      end
    endcase
  end

`ifdef ALU_EXEC_MULT_EN

  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_accNext;

  assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign outready  = !reset && (r_state == IDLE);

  // The multiplicand shifts left and the multiplier right, so bit 0 of r_mplier
  // always selects whether the current partial product is added.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      outvalid    <= 1'b0;
      outresult   <= '0;
      outzero     <= 1'b0;
      outoverflow <= 1'b0;
    end else begin
      outvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (invalid) begin
            if (inalucontrol == OP_MUL) begin
              r_mcand  <= ina;
              r_mplier <= inb;
              r_acc    <= '0;
              r_count  <= '0;
              r_state  <= MUL;
            end else begin
              outresult   <= w_result;
              outzero     <= (w_result == '0);
              outoverflow <= w_overflow;
              outvalid    <= 1'b1;
            end
          end
        end
        MUL: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (r_count == LAST_ITER) begin
            outresult   <= w_accNext;
            outzero     <= (w_accNext == '0);
            outoverflow <= 1'b0;
            outvalid    <= 1'b1;
            r_count     <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`else

  assign outready = !reset;

  // Every request completes in the cycle it is accepted, so the stage is never busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      outvalid    <= 1'b0;
      outresult   <= '0;
      outzero     <= 1'b0;
      outoverflow <= 1'b0;
    end else begin
      outvalid <= 1'b0;
      if (invalid) begin
        outresult   <= w_result;
        outzero     <= (w_result == '0);
        outoverflow <= w_overflow;
        outvalid    <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq; multiplier tests run when ALU_EXEC_MULT_EN is defined.
module tb_alu_exec_seq;

  logic        clk;
  logic        reset;
  logic        invalid;
  logic [3:0]  inalucontrol;
  logic [31:0] ina;
  logic [31:0] inb;
  logic        outready;
  logic        outvalid;
  logic [31:0] outresult;
  logic        outzero;
  logic        outoverflow;

  int errors = 0;
  int checks = 0;

  alu_exec_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .invalid     (invalid),
    .inalucontrol(inalucontrol),
    .ina         (ina),
    .inb         (inb),
    .outready    (outready),
    .outvalid    (outvalid),
    .outresult   (outresult),
    .outzero     (outzero),
    .outoverflow (outoverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    invalid      = v;
    inalucontrol = op;
    ina          = a;
    inb          = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic v, input logic [31:0] r,
                             input logic z, input logic o);
    checkOutput({tag, ".valid"}, {31'd0, outvalid}, {31'd0, v});
    checkOutput({tag, ".result"}, outresult, r);
    checkOutput({tag, ".zero"}, {31'd0, outzero}, {31'd0, z});
    checkOutput({tag, ".ovf"}, {31'd0, outoverflow}, {31'd0, o});
  endtask

  initial begin
    int badCycles;
    int pulses;
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0010, 32'd0, 32'd0);

    // Reset held for two edges
    @(negedge clk);
    checkOutput("rst.ready", {31'd0, outready}, 32'd0);
    @(negedge clk);
    checkResult("rst", 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("rst.ready2", {31'd0, outready}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("idle.ready", {31'd0, outready}, 32'd1);
    @(negedge clk);
    checkResult("idle", 1'b0, 32'd0, 1'b0, 1'b0);

    // Back-to-back single-cycle ops
    applyStimulus(1'b1, 4'b0010, 32'd5, 32'd7);
    @(negedge clk);
    checkResult("add", 1'b1, 32'd12, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0110, 32'd9, 32'd9);
    @(negedge clk);
    checkResult("sub0", 1'b1, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0);
    @(negedge clk);
    checkResult("and", 1'b1, 32'h00F000F0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0);
    @(negedge clk);
    checkResult("or", 1'b1, 32'hFFF0FFF0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1100, 32'd0, 32'd0);
    @(negedge clk);
    checkResult("nor", 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    checkResult("slt", 1'b1, 32'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0111, 32'd1, 32'hFFFFFFFF);
    @(negedge clk);
    checkResult("sltNeg", 1'b1, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0010, 32'd100, 32'd100);
    @(negedge clk);
    checkResult("hold", 1'b0, 32'd0, 1'b1, 1'b0);

    // Signed overflow and default-as-ADD codes
    applyStimulus(1'b1, 4'b0010, 32'h7FFFFFFF, 32'd1);
    @(negedge clk);
    checkResult("addOvf", 1'b1, 32'h80000000, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b0110, 32'h80000000, 32'd1);
    @(negedge clk);
    checkResult("subOvf", 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b0011, 32'd2, 32'd3);
    @(negedge clk);
    checkResult("dflt", 1'b1, 32'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0110, 32'd3, 32'd5);
    @(negedge clk);
    checkResult("subNeg", 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0010, 32'd0, 32'd0);
    @(negedge clk);

`ifdef ALU_EXEC_MULT_EN
    // Multiply: busy for 32 edges, intervening requests ignored
    applyStimulus(1'b1, 4'b1000, 32'h00012345, 32'h00000100);
    @(negedge clk);
    applyStimulus(1'b1, 4'b0010, 32'hDEAD0000, 32'h0000BEEF);
    badCycles = 0;
    for (int j = 0; j < 32; j++) begin
      if (outready !== 1'b0 || outvalid !== 1'b0 || outresult !== 32'hFFFFFFFE)
        badCycles++;
      @(negedge clk);
    end
    checkOutput("mul1.busy", badCycles, 0);
    checkResult("mul1", 1'b1, 32'h01234500, 1'b0, 1'b0);
    checkOutput("mul1.ready", {31'd0, outready}, 32'd1);
    applyStimulus(1'b0, 4'b0010, 32'd0, 32'd0);
    @(negedge clk);
    checkResult("mul1.after", 1'b0, 32'h01234500, 1'b0, 1'b0);

    applyStimulus(1'b1, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    applyStimulus(1'b0, 4'b1000, 32'd0, 32'd0);
    repeat (32) @(negedge clk);
    checkResult("mul2", 1'b1, 32'h00000001, 1'b0, 1'b0);

    // Reset during a multiply aborts it
    applyStimulus(1'b1, 4'b1000, 32'd6, 32'd7);
    @(negedge clk);
    applyStimulus(1'b0, 4'b0010, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResult("abort", 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("abort.ready", {31'd0, outready}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("abort.readyRel", {31'd0, outready}, 32'd1);
    applyStimulus(1'b1, 4'b0010, 32'd1, 32'd1);
    @(negedge clk);
    checkResult("abort.add", 1'b1, 32'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0010, 32'd0, 32'd0);
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (outvalid !== 1'b0 || outready !== 1'b1) pulses++;
    end
    checkOutput("abort.quiet", pulses, 0);
`else
    // Code 1000 without the multiplier is a single-cycle ADD
    applyStimulus(1'b1, 4'b1000, 32'd3, 32'd4);
    #1;
    checkOutput("mulAdd.readyPre", {31'd0, outready}, 32'd1);
    @(negedge clk);
    checkResult("mulAdd", 1'b1, 32'd7, 1'b0, 1'b0);
    checkOutput("mulAdd.ready", {31'd0, outready}, 32'd1);
    applyStimulus(1'b0, 4'b0010, 32'd0, 32'd0);
    @(negedge clk);
    checkResult("mulAdd.after", 1'b0, 32'd7, 1'b0, 1'b0);
`endif

    // Reset wins over a simultaneous request
    applyStimulus(1'b1, 4'b0010, 32'd8, 32'd8);
    reset = 1'b1;
    @(negedge clk);
    checkResult("rstPrio", 1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 4'b0010, 32'd0, 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
